// File: rtl/l2_scrub_pkg.sv
// rtl/l2_scrub_pkg.sv - shared types and defaults for the L2 ECC scrubber
package l2_scrub_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READ,
    ST_RESP,
    ST_WB
  } scrub_state_e;

  localparam int unsigned DefCntWidth = 16;

endpackage

// File: rtl/l2_scrub_ctrl.sv
// rtl/l2_scrub_ctrl.sv - background L2 scrubber: paced reads, ECC write-back, error counters
module l2_scrub_ctrl
  import l2_scrub_pkg::*;
#(
  parameter longint unsigned BaseAddr  = 64'h78000000,
  parameter int unsigned     NumWords  = 16384,
  parameter int unsigned     AddrWidth = 48,
  parameter int unsigned     DataWidth = 64,
  parameter int unsigned     CntWidth  = DefCntWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic [31:0]          interval_i,
  input  logic                 busy_i,
  output logic                 req_o,
  output logic                 we_o,
  output logic [AddrWidth-1:0] addr_o,
  output logic [DataWidth-1:0] wdata_o,
  input  logic                 gnt_i,
  input  logic                 rvalid_i,
  input  logic [DataWidth-1:0] rdata_i,
  input  logic                 ecc_corr_i,
  input  logic                 ecc_uncorr_i,
  output logic [CntWidth-1:0]  corr_cnt_o,
  output logic [CntWidth-1:0]  uncorr_cnt_o,
  output logic [AddrWidth-1:0] err_addr_o,
  output logic                 irq_o,
  output logic                 sweep_done_o,
  input  logic                 clr_i
);

  localparam int unsigned           IdxWidth = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam logic [AddrWidth-1:0]  Base     = AddrWidth'(BaseAddr);
  localparam logic [IdxWidth-1:0]   LastIdx  = IdxWidth'(NumWords - 1);

  scrub_state_e         state;
  logic [IdxWidth-1:0]  idx;
  logic [31:0]          timer;
  logic [AddrWidth-1:0] cur_addr;
  logic                 corr_inc;
  logic                 uncorr_inc;
  logic                 advance;

  assign cur_addr = Base + (AddrWidth'(idx) << 3);
  // The bus sees the base address whenever no request is outstanding.
  assign addr_o   = req_o ? cur_addr : Base;

  // An uncorrectable flag always wins, so a double-flagged word is never written back.
  assign corr_inc   = (state == ST_RESP) && rvalid_i && ecc_corr_i && !ecc_uncorr_i;
  assign uncorr_inc = (state == ST_RESP) && rvalid_i && ecc_uncorr_i;
  assign advance    = ((state == ST_RESP) && rvalid_i && !corr_inc) ||
                      ((state == ST_WB) && gnt_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= ST_IDLE;
      idx          <= '0;
      timer        <= '0;
      req_o        <= 1'b0;
      we_o         <= 1'b0;
      wdata_o      <= '0;
      irq_o        <= 1'b0;
      sweep_done_o <= 1'b0;
    end else begin
      irq_o        <= 1'b0;
      sweep_done_o <= 1'b0;
      if (advance) begin
        idx          <= (idx == LastIdx) ? '0 : idx + IdxWidth'(1);
        sweep_done_o <= (idx == LastIdx);
        irq_o        <= uncorr_inc;
        req_o        <= 1'b0;
        we_o         <= 1'b0;
        if (enable_i) begin
          state <= ST_WAIT;
          timer <= interval_i;
        end else begin
          state <= ST_IDLE;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (enable_i) begin
              state <= ST_WAIT;
              timer <= interval_i;
            end
          end
          ST_WAIT: begin
            if (!enable_i) begin
              state <= ST_IDLE;
            end else if (timer != '0) begin
              timer <= timer - 32'd1;
            end else if (!busy_i) begin
              state <= ST_READ;
              req_o <= 1'b1;
              we_o  <= 1'b0;
            end
          end
          ST_READ: begin
            // A grant in the same cycle as disable still completes the read.
            if (gnt_i) begin
              state <= ST_RESP;
              req_o <= 1'b0;
            end else if (!enable_i) begin
              state <= ST_IDLE;
              req_o <= 1'b0;
            end
          end
          ST_RESP: begin
            if (corr_inc) begin
              state   <= ST_WB;
              req_o   <= 1'b1;
              we_o    <= 1'b1;
              wdata_o <= rdata_i;
            end
          end
          ST_WB: begin
          end
          default: begin
            state <= ST_IDLE;
            req_o <= 1'b0;
            we_o  <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      corr_cnt_o   <= '0;
      uncorr_cnt_o <= '0;
      err_addr_o   <= '0;
    end else if (clr_i) begin
      corr_cnt_o   <= CntWidth'(corr_inc);
      uncorr_cnt_o <= CntWidth'(uncorr_inc);
      err_addr_o   <= '0;
    end else begin
      if (corr_inc && (corr_cnt_o != '1)) begin
        corr_cnt_o <= corr_cnt_o + CntWidth'(1);
      end
      if (uncorr_inc && (uncorr_cnt_o != '1)) begin
        uncorr_cnt_o <= uncorr_cnt_o + CntWidth'(1);
      end
      if (uncorr_inc) begin
        err_addr_o <= cur_addr;
      end
    end
  end

endmodule

// File: tb/tb_l2_scrub_ctrl.sv
// tb/tb_l2_scrub_ctrl.sv - directed scoreboard bench for l2_scrub_ctrl
module tb_l2_scrub_ctrl;

  localparam int          NW      = 8;
  localparam int          CW      = 2;
  localparam int          CNT_MAX = (1 << CW) - 1;
  localparam logic [47:0] BASE    = 48'h78000000;

  typedef struct packed {
    logic        we;
    logic [47:0] addr;
    logic [63:0] wdata;
  } exp_t;

  logic          clk;
  logic          rst_ni;
  logic          enable_i;
  logic [31:0]   interval_i;
  logic          busy_i;
  logic          req_o;
  logic          we_o;
  logic [47:0]   addr_o;
  logic [63:0]   wdata_o;
  logic          gnt_i;
  logic          rvalid_i;
  logic [63:0]   rdata_i;
  logic          ecc_corr_i;
  logic          ecc_uncorr_i;
  logic [CW-1:0] corr_cnt_o;
  logic [CW-1:0] uncorr_cnt_o;
  logic [47:0]   err_addr_o;
  logic          irq_o;
  logic          sweep_done_o;
  logic          clr_i;

  int          total = 0;
  int          bad   = 0;
  exp_t        sb[$];
  int          exp_idx    = 0;
  int          exp_corr   = 0;
  int          exp_uncorr = 0;
  logic [47:0] exp_err    = '0;

  l2_scrub_ctrl #(
    .BaseAddr (64'h78000000),
    .NumWords (NW),
    .AddrWidth(48),
    .DataWidth(64),
    .CntWidth (CW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .enable_i    (enable_i),
    .interval_i  (interval_i),
    .busy_i      (busy_i),
    .req_o       (req_o),
    .we_o        (we_o),
    .addr_o      (addr_o),
    .wdata_o     (wdata_o),
    .gnt_i       (gnt_i),
    .rvalid_i    (rvalid_i),
    .rdata_i     (rdata_i),
    .ecc_corr_i  (ecc_corr_i),
    .ecc_uncorr_i(ecc_uncorr_i),
    .corr_cnt_o  (corr_cnt_o),
    .uncorr_cnt_o(uncorr_cnt_o),
    .err_addr_o  (err_addr_o),
    .irq_o       (irq_o),
    .sweep_done_o(sweep_done_o),
    .clr_i       (clr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] addr_of(input int i);
    return BASE + 48'(i) * 48'd8;
  endfunction

  function automatic int sat(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic check_counters(input string tag);
    chk({tag, "_corr_cnt"}, 64'(corr_cnt_o), 64'(exp_corr));
    chk({tag, "_uncorr_cnt"}, 64'(uncorr_cnt_o), 64'(exp_uncorr));
    chk({tag, "_err_addr"}, 64'(err_addr_o), 64'(exp_err));
  endtask

  // One scrub access: wait for the read, grant after gnt_dly cycles, answer with the given flags.
  task automatic txn(input bit corr, input bit uncorr, input logic [63:0] rd,
                     input int gnt_dly, input bit drop_en, input bit clr_now);
    exp_t e;
    int   n;
    bit   wr;
    bit   wrap;
    sb.push_back('{we: 1'b0, addr: addr_of(exp_idx), wdata: 64'h0});
    n = 0;
    while (!req_o && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", 64'(req_o), 64'd1);
    e = sb.pop_front();
    for (int i = 0; i < gnt_dly; i++) begin
      chk("addr_hold", 64'(addr_o), 64'(e.addr));
      chk("req_hold", 64'(req_o), 64'd1);
      @(negedge clk);
    end
    chk("rd_addr", 64'(addr_o), 64'(e.addr));
    chk("rd_we", 64'(we_o), 64'(e.we));
    gnt_i = 1'b1;
    @(negedge clk);
    gnt_i = 1'b0;
    if (drop_en) enable_i = 1'b0;
    rvalid_i     = 1'b1;
    ecc_corr_i   = corr;
    ecc_uncorr_i = uncorr;
    rdata_i      = rd;
    clr_i        = clr_now;
    wr   = corr && !uncorr;
    wrap = (exp_idx == NW - 1);
    if (clr_now) begin
      exp_corr   = 0;
      exp_uncorr = 0;
      exp_err    = '0;
    end
    if (uncorr) begin
      exp_uncorr = sat(exp_uncorr);
      if (!clr_now) exp_err = addr_of(exp_idx);
    end else if (corr) begin
      exp_corr = sat(exp_corr);
      sb.push_back('{we: 1'b1, addr: addr_of(exp_idx), wdata: rd});
    end
    @(negedge clk);
    rvalid_i     = 1'b0;
    ecc_corr_i   = 1'b0;
    ecc_uncorr_i = 1'b0;
    clr_i        = 1'b0;
    chk("irq", 64'(irq_o), 64'(uncorr));
    check_counters("resp");
    if (wr) begin
      chk("wb_req", 64'(req_o), 64'd1);
      e = sb.pop_front();
      chk("wb_addr", 64'(addr_o), 64'(e.addr));
      chk("wb_we", 64'(we_o), 64'(e.we));
      chk("wb_wdata", wdata_o, e.wdata);
      gnt_i = 1'b1;
      @(negedge clk);
      gnt_i = 1'b0;
      chk("wb_req_drop", 64'(req_o), 64'd0);
    end
    chk("sweep_done", 64'(sweep_done_o), 64'(wrap));
    exp_idx = (exp_idx + 1) % NW;
    if (uncorr) begin
      @(negedge clk);
      chk("irq_one_cycle", 64'(irq_o), 64'd0);
    end
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    bit saw;
    saw = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (req_o) saw = 1'b1;
    end
    chk(tag, 64'(saw), 64'd0);
  endtask

  initial begin
    int k;
    rst_ni       = 1'b0;
    enable_i     = 1'b0;
    interval_i   = 32'd3;
    busy_i       = 1'b0;
    gnt_i        = 1'b0;
    rvalid_i     = 1'b0;
    rdata_i      = '0;
    ecc_corr_i   = 1'b0;
    ecc_uncorr_i = 1'b0;
    clr_i        = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", 64'(req_o), 64'd0);
    chk("rst_we", 64'(we_o), 64'd0);
    chk("rst_addr", 64'(addr_o), 64'(BASE));
    chk("rst_wdata", wdata_o, 64'd0);
    chk("rst_irq", 64'(irq_o), 64'd0);
    chk("rst_sweep", 64'(sweep_done_o), 64'd0);
    check_counters("rst");
    rst_ni = 1'b1;
    expect_quiet("idle_no_req", 5);

    // interval 3: WAIT entered on the first edge, request interval+1 edges later
    enable_i = 1'b1;
    @(negedge clk);
    k = 0;
    while (!req_o && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("latency", 64'(k), 64'd4);

    txn(1'b0, 1'b0, 64'h0, 0, 1'b0, 1'b0);
    txn(1'b0, 1'b0, 64'h0, 5, 1'b0, 1'b0);
    txn(1'b1, 1'b0, 64'hDEAD, 0, 1'b0, 1'b0);
    txn(1'b0, 1'b0, 64'h0, 0, 1'b0, 1'b0);

    busy_i = 1'b1;
    expect_quiet("busy_no_req", 14);
    busy_i = 1'b0;
    txn(1'b0, 1'b0, 64'h0, 1, 1'b0, 1'b0);

    txn(1'b0, 1'b1, 64'h0, 0, 1'b0, 1'b0);
    txn(1'b1, 1'b1, 64'h1234, 0, 1'b0, 1'b0);
    txn(1'b0, 1'b0, 64'h0, 0, 1'b0, 1'b0);

    // disable while RESP: the read completes, then the scrubber parks
    txn(1'b0, 1'b0, 64'h0, 0, 1'b1, 1'b0);
    expect_quiet("resp_disable_idle", 20);
    enable_i = 1'b1;
    txn(1'b1, 1'b0, 64'hA1, 0, 1'b0, 1'b0);
    txn(1'b1, 1'b0, 64'hA2, 2, 1'b0, 1'b0);
    txn(1'b1, 1'b0, 64'hA3, 0, 1'b0, 1'b0);

    txn(1'b0, 1'b1, 64'h0, 0, 1'b0, 1'b1);

    // disable in READ before grant: no transaction, index kept
    k = 0;
    while (!req_o && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("read_req_seen", 64'(req_o), 64'd1);
    enable_i = 1'b0;
    @(negedge clk);
    chk("read_disable_req", 64'(req_o), 64'd0);
    expect_quiet("read_disable_idle", 8);
    enable_i = 1'b1;
    txn(1'b0, 1'b0, 64'h0, 0, 1'b0, 1'b0);

    k = 0;
    while (!req_o && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("pre_reset_req", 64'(req_o), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_req", 64'(req_o), 64'd0);
    chk("async_rst_addr", 64'(addr_o), 64'(BASE));
    chk("async_rst_uncorr", 64'(uncorr_cnt_o), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
